// File: rtl/pipemem.sv
`default_nettype none
// ============================================================================
// Module   : pipemem
// Purpose  : Pipelined load/store unit bridging the ZipCPU core to a global
//            and a local Wishbone B4 pipelined bus. Up to 1<<LGDEPTH requests
//            may be in flight within one bus cycle. Byte/half/word access with
//            big-endian lanes; loads are zero-extended. Misaligned accesses
//            and bus errors raise a one-cycle o_err pulse.
// Options  : define ZIPMEM_LOCK_EN to honour i_lock (bus held across ops).
// Revision : 1.0 - initial release
// ============================================================================
module pipemem #(
  parameter int AW      = 30,
  parameter int LGDEPTH = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stb,
  input  logic [2:0]    i_op,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_data,
  input  logic [4:0]    i_oreg,
  input  logic          i_lock,
  output logic          o_busy,
  output logic          o_pipe_stalled,
  output logic          o_valid,
  output logic          o_err,
  output logic [4:0]    o_wreg,
  output logic [31:0]   o_result,
  output logic          o_wb_cyc_gbl,
  output logic          o_wb_stb_gbl,
  output logic          o_wb_cyc_lcl,
  output logic          o_wb_stb_lcl,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0]   C_FULL    = (LGDEPTH+1)'(DEPTH);
  localparam logic [LGDEPTH:0]   C_CNT_ONE = (LGDEPTH+1)'(1);
  localparam logic [LGDEPTH-1:0] C_PTR_ONE = LGDEPTH'(1);

  // Size encodings carried in i_op[2:1]
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_BYTE = 2'b10;

  // Bus-side state
  logic              cyc_gbl_q, cyc_gbl_d;
  logic              cyc_lcl_q, cyc_lcl_d;
  logic              stb_q,     stb_d;
  logic              we_q,      we_d;
  logic [AW-1:0]     addr_q,    addr_d;
  logic [31:0]       data_q,    data_d;
  logic [3:0]        sel_q,     sel_d;
  logic [LGDEPTH:0]  count_q,   count_d;

  // Return-path FIFO: {oreg, size, byte offset}
  logic [8:0]         fifo_q [DEPTH];
  logic [LGDEPTH-1:0] wr_q, wr_d;
  logic [LGDEPTH-1:0] rd_q, rd_d;

  // Core-side result registers
  logic        valid_q,  valid_d;
  logic        err_q,    err_d;
  logic [4:0]  wreg_q,   wreg_d;
  logic [31:0] result_q, result_d;

  // Request decode
  logic [1:0]  w_size;
  logic        w_is_byte, w_is_half, w_is_word;
  logic        w_misaligned, w_lcl, w_cyc, w_bus_differs, w_err_flush;
  logic        w_accept, w_mis_trap, w_ack, w_hold;
  logic [31:0] w_wdata;
  logic [3:0]  w_sel;
  logic [8:0]  w_head;
  logic [4:0]  w_head_oreg;
  logic [1:0]  w_head_size, w_head_off;
  logic [7:0]  w_rbyte;
  logic [31:0] w_rdata;

`ifdef ZIPMEM_LOCK_EN
  assign w_hold = i_lock;
`else
  // Lock input has no effect in this build
  assign w_hold = i_lock & 1'b0;
`endif

  assign w_size      = i_op[2:1];
  assign w_is_byte   = (w_size == C_SZ_BYTE);
  assign w_is_half   = (w_size == C_SZ_HALF);
  assign w_is_word   = !w_is_byte && !w_is_half;  // 11 is treated as word
  assign w_misaligned = (w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00));
  assign w_lcl       = (i_addr[31:8] == 24'hc00000) && (i_addr[7:5] == 3'b000);
  assign w_cyc       = cyc_gbl_q || cyc_lcl_q;
  // While a cycle is open exactly one cyc is high; compare the request's bus to it
  assign w_bus_differs = (w_lcl != cyc_lcl_q);
  assign w_err_flush = w_cyc && i_wb_err;

  assign o_pipe_stalled = (stb_q && i_wb_stall)
                        || (count_q == C_FULL)
                        || (w_cyc && (w_bus_differs || (i_op[0] != we_q)))
                        || w_err_flush;

  assign w_accept   = i_stb && !o_pipe_stalled && !w_misaligned;
  assign w_mis_trap = i_stb && !o_pipe_stalled &&  w_misaligned;
  // Acks count only inside an open cycle with something outstanding; an error wins
  assign w_ack      = w_cyc && i_wb_ack && !i_wb_err && (count_q != '0);

  // Store lane steering: replicate narrow data, select lanes big-endian
  always_comb begin
    w_wdata = i_data;
    w_sel   = 4'b1111;
    if (w_is_byte) begin
      w_wdata = {4{i_data[7:0]}};
      w_sel   = 4'b1000 >> i_addr[1:0];
    end else if (w_is_half) begin
      w_wdata = {2{i_data[15:0]}};
      w_sel   = i_addr[1] ? 4'b0011 : 4'b1100;
    end
  end

  assign w_head      = fifo_q[rd_q];
  assign w_head_oreg = w_head[8:4];
  assign w_head_size = w_head[3:2];
  assign w_head_off  = w_head[1:0];

  // Load alignment: pick the addressed lane(s) and zero-extend
  always_comb begin
    w_rbyte = i_wb_data[7:0];
    case (w_head_off)
      2'd0:    w_rbyte = i_wb_data[31:24];
      2'd1:    w_rbyte = i_wb_data[23:16];
      2'd2:    w_rbyte = i_wb_data[15:8];
      default: w_rbyte = i_wb_data[7:0];
    endcase
    w_rdata = i_wb_data;
    if (w_head_size == C_SZ_BYTE) begin
      w_rdata = {24'h0, w_rbyte};
    end else if (w_head_size == C_SZ_HALF) begin
      w_rdata = w_head_off[1] ? {16'h0, i_wb_data[15:0]} : {16'h0, i_wb_data[31:16]};
    end
  end

  // Next-state for bus control, request registers, counter, FIFO pointers and results
  always_comb begin
    cyc_gbl_d = cyc_gbl_q;
    cyc_lcl_d = cyc_lcl_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    count_d   = count_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    valid_d   = 1'b0;
    err_d     = w_mis_trap;
    wreg_d    = wreg_q;
    result_d  = result_q;

    if (w_accept) begin
      count_d = count_d + C_CNT_ONE;
      wr_d    = wr_q + C_PTR_ONE;
      we_d    = i_op[0];
      addr_d  = i_addr[AW+1:2];
      data_d  = w_wdata;
      sel_d   = w_sel;
    end

    if (w_ack) begin
      count_d = count_d - C_CNT_ONE;
      rd_d    = rd_q + C_PTR_ONE;
      if (!we_q) begin
        valid_d  = 1'b1;
        wreg_d   = w_head_oreg;
        result_d = w_rdata;
      end
    end

    if (w_err_flush) begin
      cyc_gbl_d = 1'b0;
      cyc_lcl_d = 1'b0;
      stb_d     = 1'b0;
      count_d   = '0;
      wr_d      = '0;
      rd_d      = '0;
      err_d     = 1'b1;
    end else if (w_accept) begin
      cyc_gbl_d = !w_lcl;
      cyc_lcl_d = w_lcl;
      stb_d     = 1'b1;
    end else begin
      stb_d = stb_q && i_wb_stall;
      if ((count_d == '0) && !w_hold) begin
        cyc_gbl_d = 1'b0;
        cyc_lcl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cyc_gbl_q <= 1'b0;
      cyc_lcl_q <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wreg_q    <= '0;
      result_q  <= '0;
    end else begin
      cyc_gbl_q <= cyc_gbl_d;
      cyc_lcl_q <= cyc_lcl_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      wreg_q    <= wreg_d;
      result_q  <= result_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      fifo_q[wr_q] <= {i_oreg, w_size, i_addr[1:0]};
    end
  end

  assign o_busy       = (count_q != '0) || w_cyc;
  assign o_valid      = valid_q;
  assign o_err        = err_q;
  assign o_wreg       = wreg_q;
  assign o_result     = result_q;
  assign o_wb_cyc_gbl = cyc_gbl_q;
  assign o_wb_cyc_lcl = cyc_lcl_q;
  assign o_wb_stb_gbl = stb_q && cyc_gbl_q;
  assign o_wb_stb_lcl = stb_q && cyc_lcl_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = sel_q;

endmodule
`default_nettype wire
